apb_modport: RTL and testbench
==============================

// Module: apb_modport
// PURPOSE
// - Self-contained APB subsystem: an APB master FSM driving two internal APB slave memories.
// - Takes simple command inputs (transfer, READ_WRITE, addresses, write data) and runs
//   APB SETUP/ACCESS cycles internally.
// - Returns read data and slave error to the testbench side.
// - Top-level DUT behind the apb_if DRV/MON modports.
// PARAMETERS
// - ADDR_WIDTH  8  slave-local address bits; the external address is ADDR_WIDTH+1 bits, MSB = slave select.
// - DATA_WIDTH  8  data word width.
// PORTS
// - PCLK               in   1             system clock; all state changes on rising edge.
// - PRESETn            in   1             reset; one clock; reset is asynchronous and active-high.
// - transfer           in   1             request a transaction (level, sampled each edge).
// - READ_WRITE         in   1             0 = read, 1 = write.
// - apb_write_paddr    in   ADDR_WIDTH+1  write address; MSB 0 = slave1, 1 = slave2.
// - apb_read_paddr     in   ADDR_WIDTH+1  read address, same decode.
// - apb_write_data     in   DATA_WIDTH    write data.
// - apb_read_data_out  out  DATA_WIDTH    last completed read data (registered).
// - PSLVERR            out  1             error flag of last completed transfer (registered).
// BEHAVIOUR
// - Reset (PRESETn=1, async):
//   - FSM -> IDLE; apb_read_data_out=0; PSLVERR=0.
//   - All internal PSEL/PENABLE/PWRITE/PADDR/PWDATA = 0.
//   - All per-word valid bits cleared. Memory data content is don't-care.
// - Master FSM states IDLE, SETUP, ACCESS:
//   - IDLE: transfer=1 -> SETUP, else stay in IDLE.
//   - SETUP: unconditionally -> ACCESS.
//   - ACCESS: PREADY=1 and transfer=1 -> SETUP (back-to-back); PREADY=1 and transfer=0 -> IDLE;
//     PREADY=0 -> stay in ACCESS.
// - Command capture:
//   - Captured on the edge that enters SETUP (from IDLE or ACCESS).
//   - Captured fields: READ_WRITE; apb_write_paddr when write, apb_read_paddr when read;
//     apb_write_data.
//   - Captured values are held stable through SETUP and ACCESS, regardless of input changes.
// - APB outputs:
//   - SETUP: PSEL of the addressed slave=1, PENABLE=0.
//   - ACCESS: PSEL=1, PENABLE=1.
//   - IDLE: both 0. Only one PSEL may be active at a time.
// - Slaves:
//   - 2^ADDR_WIDTH x DATA_WIDTH memory each, plus one valid bit per word.
//   - Zero wait states: PREADY=1 in ACCESS.
// - Write completion (edge ending ACCESS):
//   - mem[addr] <= wdata; valid[addr] <= 1; PSLVERR <= 0.
//   - apb_read_data_out is unchanged.
// - Read completion (same edge):
//   - Valid word: apb_read_data_out <= mem[addr]; PSLVERR <= 0.
//   - Unwritten word: apb_read_data_out <= 0; PSLVERR <= 1.
// - Latency:
//   - transfer sampled at edge N: SETUP after N, ACCESS after N+1.
//   - Completion and output update at edge N+2.
//   - Back-to-back: one transaction completes every 2 cycles.
// - Outputs hold their values between completions.
// - Reset asserted mid-transaction aborts it: no memory write, outputs cleared immediately.
// - Write then read of the same address in consecutive transactions returns the new data.
// - Address MSB selects the slave; the low ADDR_WIDTH bits index the word.
//   Address wrap-around is not applicable.
// TESTING
// - Reset: PRESETn=1 mid-stream -> apb_read_data_out=0x00, PSLVERR=0; FSM in IDLE next cycle.
// - Write 0x3C @0x0A5, then read 0x0A5 -> apb_read_data_out=0x3C, PSLVERR=0,
//   valid 2 edges after transfer sampled.
// - Slave decode: write 0x11 @0x105 and 0x22 @0x005; read 0x105 -> 0x11; read 0x005 -> 0x22.
// - Unwritten read: read 0x1FF after reset -> apb_read_data_out=0x00, PSLVERR=1;
//   next good read clears PSLVERR.
// - Back-to-back: transfer held high for 4 writes (0x01..0x04 @0x010..0x013), then 4 reads
//   -> 0x01..0x04, one completion every 2 cycles, no IDLE between.
// - Reset during ACCESS of write 0xAA @0x020 -> subsequent read 0x020 returns 0x00 with PSLVERR=1.

Source files
------------

// File: rtl/apb_modport.sv
// apb_modport: self-contained APB subsystem. A master FSM turns simple command
// inputs into APB SETUP/ACCESS cycles against two internal zero-wait slave
// memories and returns the result of the last completed transfer.
//
// Ports
//   PCLK               in   clock, all state changes on the rising edge
//   PRESETn            in   asynchronous reset, active HIGH despite the name
//   transfer           in   request a transaction (level, sampled each edge)
//   READ_WRITE         in   0 = read, 1 = write
//   apb_write_paddr    in   [ADDR_WIDTH:0] write address, MSB selects slave
//   apb_read_paddr     in   [ADDR_WIDTH:0] read address, same decode
//   apb_write_data     in   [DATA_WIDTH-1:0] write data
//   apb_read_data_out  out  [DATA_WIDTH-1:0] last completed read data
//   PSLVERR            out  error flag of the last completed transfer

// One slave: word memory plus a per-word valid bit. Reading a word that was
// never written since reset returns 0 and raises pslverr.
module apb_slave #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  PCLK,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);
  localparam int WORDS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:WORDS-1];
  logic [WORDS-1:0]      vld;
  logic                  acc;

  assign acc    = psel & penable;
  assign pready = acc;  // zero wait states

  // Data array carries no reset; vld guards every read.
  always_ff @(posedge PCLK)
    if (acc && pwrite) mem[paddr] <= pwdata;

  always_ff @(posedge PCLK or posedge rst)
    if (rst)                vld        <= '0;
    else if (acc && pwrite) vld[paddr] <= 1'b1;

  assign prdata  = vld[paddr] ? mem[paddr] : '0;
  assign pslverr = acc & ~pwrite & ~vld[paddr];
endmodule

module apb_modport #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  transfer,
  input  logic                  READ_WRITE,
  input  logic [ADDR_WIDTH:0]   apb_write_paddr,
  input  logic [ADDR_WIDTH:0]   apb_read_paddr,
  input  logic [DATA_WIDTH-1:0] apb_write_data,
  output logic [DATA_WIDTH-1:0] apb_read_data_out,
  output logic                  PSLVERR
);
  localparam int NUM_SLV = 2;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state, state_nxt;

  // Captured command, held through SETUP and ACCESS.
  logic                  pwrite;
  logic [ADDR_WIDTH:0]   paddr;
  logic [DATA_WIDTH-1:0] pwdata;

  logic                                 penable, pready, pslverr_sel, capture, done;
  logic [NUM_SLV-1:0]                   psel, pready_s, pslverr_s;
  logic [NUM_SLV-1:0][DATA_WIDTH-1:0]   prdata_s;
  logic                                 sel;

  assign sel     = paddr[ADDR_WIDTH];
  assign penable = (state == ACCESS);
  // Exactly one PSEL, and only outside IDLE.
  assign psel    = (state == IDLE) ? '0 : (sel ? 2'b10 : 2'b01);

  assign pready      = pready_s[sel];
  assign pslverr_sel = pslverr_s[sel];
  assign done        = (state == ACCESS) && pready;
  // Command is latched on every edge that enters SETUP.
  assign capture     = transfer && ((state == IDLE) || done);

  always_ff @(posedge PCLK or posedge PRESETn)
    if (PRESETn) state <= IDLE;
    else         state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (transfer) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (pready) state_nxt = transfer ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESETn)
    if (PRESETn) begin
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
    end else if (capture) begin
      pwrite <= READ_WRITE;
      paddr  <= READ_WRITE ? apb_write_paddr : apb_read_paddr;
      pwdata <= apb_write_data;
    end

  // Result registers: reads update data and error, writes only clear error.
  always_ff @(posedge PCLK or posedge PRESETn)
    if (PRESETn) begin
      apb_read_data_out <= '0;
      PSLVERR           <= 1'b0;
    end else if (done) begin
      if (!pwrite) apb_read_data_out <= prdata_s[sel];
      PSLVERR <= pslverr_sel;
    end

  for (genvar s = 0; s < NUM_SLV; s++) begin : g_slv
    apb_slave #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_slv (
      .PCLK    (PCLK),
      .rst     (PRESETn),
      .psel    (psel[s]),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr[ADDR_WIDTH-1:0]),
      .pwdata  (pwdata),
      .prdata  (prdata_s[s]),
      .pready  (pready_s[s]),
      .pslverr (pslverr_s[s])
    );
  end
endmodule

// File: tb/tb_apb_modport.sv
module tb_apb_modport;
  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b1;
  logic       transfer = 1'b0;
  logic       READ_WRITE = 1'b0;
  logic [8:0] apb_write_paddr = '0;
  logic [8:0] apb_read_paddr = '0;
  logic [7:0] apb_write_data = '0;
  logic [7:0] apb_read_data_out;
  logic       PSLVERR;

  apb_modport #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .PCLK              (PCLK),
    .PRESETn           (PRESETn),
    .transfer          (transfer),
    .READ_WRITE        (READ_WRITE),
    .apb_write_paddr   (apb_write_paddr),
    .apb_read_paddr    (apb_read_paddr),
    .apb_write_data    (apb_write_data),
    .apb_read_data_out (apb_read_data_out),
    .PSLVERR           (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [7:0] rd;
    logic       err;
  } exp_t;

  exp_t       q[$];
  logic [7:0] model_mem [int];
  logic [7:0] m_rd = '0;
  logic       m_err = 1'b0;
  logic [7:0] cur_rd = '0;
  logic       cur_err = 1'b0;
  int         n_pass = 0;
  int         n_total = 0;

  function automatic void chk(string name, logic [7:0] act, logic [7:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, req);
  endfunction

  // Monitor: a scheduled completion becomes the new expected output state;
  // between completions the outputs must simply hold.
  initial forever begin
    @(negedge PCLK);
    #2;
    if (q.size() != 0 && q[0].due == cyc) begin
      exp_t e;
      e = q.pop_front();
      cur_rd  = e.rd;
      cur_err = e.err;
    end
    chk("rdata", apb_read_data_out, cur_rd);
    chk("pslverr", {7'd0, PSLVERR}, {7'd0, cur_err});
  end

  // One transaction; the reference model is updated in issue order.
  task automatic issue(bit rw, logic [8:0] a, logic [7:0] d, bit last);
    transfer        = 1'b1;
    READ_WRITE      = rw;
    apb_write_paddr = rw ? a : 9'($urandom);
    apb_read_paddr  = rw ? 9'($urandom) : a;
    apb_write_data  = rw ? d : 8'($urandom);
    if (rw) begin
      model_mem[int'(a)] = d;
      m_err = 1'b0;
    end else if (model_mem.exists(int'(a))) begin
      m_rd  = model_mem[int'(a)];
      m_err = 1'b0;
    end else begin
      m_rd  = 8'h00;
      m_err = 1'b1;
    end
    q.push_back('{cyc + 3, m_rd, m_err});
    @(negedge PCLK);
    // Not sampled on this edge; scramble to prove the command was captured.
    READ_WRITE      = 1'($urandom);
    apb_write_paddr = 9'($urandom);
    apb_read_paddr  = 9'($urandom);
    apb_write_data  = 8'($urandom);
    if (last) transfer = 1'b0;
    @(negedge PCLK);
  endtask

  task automatic idle(int n);
    transfer = 1'b0;
    repeat (n) @(negedge PCLK);
  endtask

  task automatic do_reset();
    PRESETn  = 1'b1;
    transfer = 1'b0;
    q.delete();
    model_mem.delete();
    m_rd = '0; m_err = 1'b0;
    cur_rd = '0; cur_err = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b0;
  endtask

  logic [8:0] pool [8];

  initial begin
    @(negedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b0;
    idle(2);

    // basic write then read
    issue(1, 9'h0A5, 8'h3C, 1);
    issue(0, 9'h0A5, 8'h00, 1);
    idle(2);

    // slave decode by address MSB
    issue(1, 9'h105, 8'h11, 1);
    issue(1, 9'h005, 8'h22, 1);
    issue(0, 9'h105, 8'h00, 1);
    issue(0, 9'h005, 8'h00, 1);
    idle(3);

    // unwritten read after reset, then a good read clears the error
    do_reset();
    idle(1);
    issue(0, 9'h1FF, 8'h00, 1);
    idle(1);
    issue(0, 9'h0A5, 8'h00, 1);
    issue(1, 9'h0A5, 8'h5A, 1);
    issue(0, 9'h0A5, 8'h00, 1);
    idle(3);

    // back-to-back burst with transfer held high
    for (int i = 0; i < 4; i++) issue(1, 9'(9'h010 + i), 8'(i + 1), 0);
    for (int i = 0; i < 4; i++) issue(0, 9'(9'h010 + i), 8'h00, i == 3);
    idle(3);

    // reset while a write is in ACCESS: write must be lost
    transfer = 1'b1; READ_WRITE = 1'b1;
    apb_write_paddr = 9'h020; apb_write_data = 8'hAA;
    @(negedge PCLK);
    transfer = 1'b0;
    @(negedge PCLK);
    do_reset();
    idle(1);
    issue(0, 9'h020, 8'h00, 1);
    idle(3);

    // randomized traffic over a small address pool, then a mid-stream reset
    for (int i = 0; i < 8; i++) pool[i] = 9'($urandom);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 40; i++) begin
        issue(1'($urandom), pool[$urandom_range(0, 7)], 8'($urandom),
              ($urandom_range(0, 3) == 0) || i == 39);
        if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      end
      if (r == 0) begin
        issue(1, pool[0], 8'($urandom), 0);
        do_reset();
        idle(2);
      end
    end

    transfer = 1'b0;
    for (int t = 0; t < 20 && q.size() != 0; t++) @(negedge PCLK);
    idle(2);
    n_total++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d completions outstanding, expected 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
